mem_lsu: RTL

- Load/store unit of the MEM stage.
- Inputs: EX_MEM pipeline register outputs (address, store data, op, enable).
- Outputs: load data and memory-mapped peripheral registers, both captured by the MEM/WB register on the next edge.
- Contains the data memory (synchronous write, combinational read), the output peripheral registers (LEDR, LEDG, LCD, HEX0-7) and a 2-flop synchronizer for the switch/key inputs.

---
 rtl/mem_lsu.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: data memory, board peripheral registers and the
// switch/key synchronizer. Loads are combinational; stores commit on the
// rising edge of i_clk.
module mem_lsu #(
  parameter int DMEM_DEPTH  = 2048,
  parameter int SYNC_STAGES = 2
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_lsu_addr,
  input  logic [31:0] i_st_data,
  input  logic        i_lsu_wren,
  input  logic [2:0]  i_lsu_op,
  input  logic        i_insn_vld,
  input  logic [31:0] i_io_sw,
  input  logic [3:0]  i_io_key,
  output logic [31:0] o_ld_data,
  output logic        o_misaligned,
  output logic [31:0] o_io_ledr,
  output logic [31:0] o_io_ledg,
  output logic [31:0] o_io_lcd,
  output logic [6:0]  o_io_hex0,
  output logic [6:0]  o_io_hex1,
  output logic [6:0]  o_io_hex2,
  output logic [6:0]  o_io_hex3,
  output logic [6:0]  o_io_hex4,
  output logic [6:0]  o_io_hex5,
  output logic [6:0]  o_io_hex6,
  output logic [6:0]  o_io_hex7
);

  localparam int          AW         = $clog2(DMEM_DEPTH);
  localparam logic [31:0] DMEM_BYTES = 32'(DMEM_DEPTH * 4);

  localparam logic [19:0] PG_LEDR  = 20'h10000;
  localparam logic [19:0] PG_LEDG  = 20'h10001;
  localparam logic [19:0] PG_HEXLO = 20'h10002;
  localparam logic [19:0] PG_HEXHI = 20'h10003;
  localparam logic [19:0] PG_LCD   = 20'h10004;
  localparam logic [19:0] PG_SW    = 20'h10010;
  localparam logic [19:0] PG_KEY   = 20'h10011;

  logic [31:0] r_dmem [DMEM_DEPTH];
  logic [31:0] r_ledr;
  logic [31:0] r_ledg;
  logic [31:0] r_lcd;
  logic [6:0]  r_hex [8];
  logic [31:0] r_sw_sync [SYNC_STAGES];
  logic [3:0]  r_key_sync [SYNC_STAGES];

  logic        w_op_b;
  logic        w_op_h;
  logic        w_op_w;
  logic        w_misaligned;
  logic        w_st_fire;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [19:0] w_page;
  logic        w_sel_dmem;
  logic        w_hit;
  logic [31:0] w_rword;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_ld;
  logic [AW-1:0] w_widx;

  assign w_op_b = (i_lsu_op == 3'b000) || (i_lsu_op == 3'b100);
  assign w_op_h = (i_lsu_op == 3'b001) || (i_lsu_op == 3'b101);
  assign w_op_w = (i_lsu_op == 3'b010);

  assign w_misaligned = i_insn_vld &&
                        ((w_op_h && i_lsu_addr[0]) ||
                         (w_op_w && (i_lsu_addr[1:0] != 2'b00)));

  // Stores only use the signed-size encodings; BU/HU and reserved codes never write.
  assign w_st_fire = i_insn_vld && i_lsu_wren && !w_misaligned && !i_lsu_op[2];

  assign w_page     = i_lsu_addr[31:12];
  assign w_sel_dmem = (i_lsu_addr < DMEM_BYTES);
  assign w_widx     = i_lsu_addr[AW+1:2];

  // Byte-lane enables and lane-replicated store data
  always_comb begin
    w_be    = 4'b0000;
    w_wdata = i_st_data;
    if (w_op_b) begin
      w_be    = 4'b0001 << i_lsu_addr[1:0];
      w_wdata = {4{i_st_data[7:0]}};
    end else if (w_op_h) begin
      w_be    = i_lsu_addr[1] ? 4'b1100 : 4'b0011;
      w_wdata = {2{i_st_data[15:0]}};
    end else if (w_op_w) begin
      w_be    = 4'b1111;
    end
  end

  // Data memory write port (contents are not reset)
  always_ff @(posedge i_clk) begin
    if (w_st_fire && w_sel_dmem) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) r_dmem[w_widx][8*b +: 8] <= w_wdata[8*b +: 8];
      end
    end
  end

  // Peripheral registers with byte-enable writes
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_ledr <= '0;
      r_ledg <= '0;
      r_lcd  <= '0;
      for (int h = 0; h < 8; h++) r_hex[h] <= '0;
    end else if (w_st_fire && !w_sel_dmem) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) begin
          if (w_page == PG_LEDR)  r_ledr[8*b +: 8] <= w_wdata[8*b +: 8];
          if (w_page == PG_LEDG)  r_ledg[8*b +: 8] <= w_wdata[8*b +: 8];
          if (w_page == PG_LCD)   r_lcd[8*b +: 8]  <= w_wdata[8*b +: 8];
          if (w_page == PG_HEXLO) r_hex[b]         <= w_wdata[8*b +: 7];
          if (w_page == PG_HEXHI) r_hex[b+4]       <= w_wdata[8*b +: 7];
        end
      end
    end
  end

  // Switch/key synchronizer chains
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        r_sw_sync[s]  <= '0;
        r_key_sync[s] <= '0;
      end
    end else begin
      r_sw_sync[0]  <= i_io_sw;
      r_key_sync[0] <= i_io_key;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        r_sw_sync[s]  <= r_sw_sync[s-1];
        r_key_sync[s] <= r_key_sync[s-1];
      end
    end
  end

  // Word read from the decoded target
  always_comb begin
    w_rword = '0;
    w_hit   = 1'b1;
    if (w_sel_dmem) begin
      w_rword = r_dmem[w_widx];
    end else begin
      case (w_page)
        PG_LEDR:  w_rword = r_ledr;
        PG_LEDG:  w_rword = r_ledg;
        PG_LCD:   w_rword = r_lcd;
        PG_HEXLO: w_rword = {1'b0, r_hex[3], 1'b0, r_hex[2], 1'b0, r_hex[1], 1'b0, r_hex[0]};
        PG_HEXHI: w_rword = {1'b0, r_hex[7], 1'b0, r_hex[6], 1'b0, r_hex[5], 1'b0, r_hex[4]};
        PG_SW:    w_rword = r_sw_sync[SYNC_STAGES-1];
        PG_KEY:   w_rword = {28'b0, r_key_sync[SYNC_STAGES-1]};
        default:  w_hit   = 1'b0;
      endcase
    end
  end

  // Sub-word selection and extension
  always_comb begin
    w_byte = w_rword[7:0];
    case (i_lsu_addr[1:0])
      2'd1:    w_byte = w_rword[15:8];
      2'd2:    w_byte = w_rword[23:16];
      2'd3:    w_byte = w_rword[31:24];
      default: w_byte = w_rword[7:0];
    endcase
    w_half = i_lsu_addr[1] ? w_rword[31:16] : w_rword[15:0];
    w_ld   = '0;
    if (i_insn_vld && !w_misaligned && w_hit) begin
      case (i_lsu_op)
        3'b000:  w_ld = {{24{w_byte[7]}}, w_byte};
        3'b100:  w_ld = {24'b0, w_byte};
        3'b001:  w_ld = {{16{w_half[15]}}, w_half};
        3'b101:  w_ld = {16'b0, w_half};
        3'b010:  w_ld = w_rword;
        default: w_ld = '0;
      endcase
    end
  end

  assign o_ld_data    = w_ld;
  assign o_misaligned = w_misaligned;
  assign o_io_ledr    = r_ledr;
  assign o_io_ledg    = r_ledg;
  assign o_io_lcd     = r_lcd;
  assign o_io_hex0    = r_hex[0];
  assign o_io_hex1    = r_hex[1];
  assign o_io_hex2    = r_hex[2];
  assign o_io_hex3    = r_hex[3];
  assign o_io_hex4    = r_hex[4];
  assign o_io_hex5    = r_hex[5];
  assign o_io_hex6    = r_hex[6];
  assign o_io_hex7    = r_hex[7];

endmodule
